// File: rtl/sound_tone_gen.sv
// Square-wave tone generator driven by game events and the sound mode FSM.
// Bad > good > move priority; a bad collision plays a two-segment descending tone.
//
// state | meaning
// IDLE  | silent, waiting for an event while mode is ON
// SEG1  | first (or only) tone segment playing
// SEG2  | second, lower-pitched segment of the bad tone
module sound_tone_gen #(
   parameter int MOVE_DIV = 2,
   parameter int GOOD_DIV = 4,
   parameter int BAD_DIV  = 6,
   parameter int DUR      = 24
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       mode_i,
   input  logic       goodColl,
   input  logic       badColl,
   input  logic [3:0] direction,
   output logic       speaker,
   output logic       busy,
   output logic [1:0] tone_id
);

   localparam logic [15:0] MOVE_HP  = 16'(MOVE_DIV);
   localparam logic [15:0] GOOD_HP  = 16'(GOOD_DIV);
   localparam logic [15:0] BAD_HP   = 16'(BAD_DIV);
   localparam logic [15:0] BAD2_HP  = 16'(2 * BAD_DIV);
   localparam logic [15:0] DUR_LAST = 16'(DUR - 1);

   localparam logic [1:0] TONE_NONE = 2'b00;
   localparam logic [1:0] TONE_MOVE = 2'b01;
   localparam logic [1:0] TONE_GOOD = 2'b10;
   localparam logic [1:0] TONE_BAD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEG1 = 2'b01,
      SEG2 = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  tone_q, tone_d;
   logic        spk_q, spk_d;
   logic        busy_q, busy_d;
   logic [15:0] hp_cnt_q, hp_cnt_d;
   logic [15:0] dur_cnt_q, dur_cnt_d;
   logic [15:0] hp_val_q, hp_val_d;
   logic [3:0]  prev_dir_q;

   logic        move_ev;
   logic [1:0]  ev_code;
   logic        start;
   logic [15:0] start_hp;

   assign move_ev = (direction != prev_dir_q) && (direction != 4'b0000);

   always_comb begin
      ev_code = TONE_NONE;
      if (badColl)       ev_code = TONE_BAD;
      else if (goodColl) ev_code = TONE_GOOD;
      else if (move_ev)  ev_code = TONE_MOVE;
   end

   // In IDLE tone_q is 00, so a strict priority compare also covers "any event while idle".
   assign start = mode_i && (ev_code != TONE_NONE) && (ev_code > tone_q);

   always_comb begin
      start_hp = MOVE_HP;
      case (ev_code)
         TONE_GOOD: start_hp = GOOD_HP;
         TONE_BAD:  start_hp = BAD_HP;
         default:   start_hp = MOVE_HP;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      tone_d    = tone_q;
      spk_d     = spk_q;
      hp_cnt_d  = hp_cnt_q;
      dur_cnt_d = dur_cnt_q;
      hp_val_d  = hp_val_q;

      if (!mode_i) begin
         state_d   = IDLE;
         tone_d    = TONE_NONE;
         spk_d     = 1'b0;
         hp_cnt_d  = '0;
         dur_cnt_d = '0;
      end else if (start) begin
         state_d   = SEG1;
         tone_d    = ev_code;
         spk_d     = 1'b1;
         hp_cnt_d  = '0;
         dur_cnt_d = '0;
         hp_val_d  = start_hp;
      end else if (state_q != IDLE) begin
         if (hp_cnt_q == hp_val_q - 16'd1) begin
            spk_d    = ~spk_q;
            hp_cnt_d = '0;
         end else begin
            hp_cnt_d = hp_cnt_q + 16'd1;
         end

         if (dur_cnt_q == DUR_LAST) begin
            if (state_q == SEG1 && tone_q == TONE_BAD) begin
               state_d   = SEG2;
               hp_val_d  = BAD2_HP;
               spk_d     = 1'b1;
               hp_cnt_d  = '0;
               dur_cnt_d = '0;
            end else begin
               state_d   = IDLE;
               tone_d    = TONE_NONE;
               spk_d     = 1'b0;
               hp_cnt_d  = '0;
               dur_cnt_d = '0;
            end
         end else begin
            dur_cnt_d = dur_cnt_q + 16'd1;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= IDLE;
         tone_q     <= TONE_NONE;
         spk_q      <= 1'b0;
         busy_q     <= 1'b0;
         hp_cnt_q   <= '0;
         dur_cnt_q  <= '0;
         hp_val_q   <= '0;
         prev_dir_q <= 4'b0000;
      end else begin
         state_q    <= state_d;
         tone_q     <= tone_d;
         spk_q      <= spk_d;
         busy_q     <= busy_d;
         hp_cnt_q   <= hp_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         hp_val_q   <= hp_val_d;
         prev_dir_q <= direction;
      end
   end

   assign speaker = spk_q;
   assign busy    = busy_q;
   assign tone_id = tone_q;

endmodule

// File: tb/tb_sound_tone_gen.sv
// Directed bench for sound_tone_gen: expected {busy,tone_id,speaker} per cycle
// is queued as stimulus is applied and checked one entry per clock.
module tb_sound_tone_gen;

   localparam int MOVE_DIV = 2;
   localparam int GOOD_DIV = 4;
   localparam int BAD_DIV  = 6;
   localparam int DUR      = 24;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       mode_i = 1'b1;
   logic       goodColl = 1'b0;
   logic       badColl = 1'b0;
   logic [3:0] direction = 4'b0000;
   logic       speaker;
   logic       busy;
   logic [1:0] tone_id;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   logic [3:0] exp_q[$];

   sound_tone_gen #(
      .MOVE_DIV(MOVE_DIV),
      .GOOD_DIV(GOOD_DIV),
      .BAD_DIV (BAD_DIV),
      .DUR     (DUR)
   ) dut (
      .clk      (clk),
      .nRst     (nRst),
      .mode_i   (mode_i),
      .goodColl (goodColl),
      .badColl  (badColl),
      .direction(direction),
      .speaker  (speaker),
      .busy     (busy),
      .tone_id  (tone_id)
   );

   always #5 clk = ~clk;

   function automatic int div_of(input logic [1:0] code);
      case (code)
         2'b01:   return MOVE_DIV;
         2'b10:   return GOOD_DIV;
         default: return BAD_DIV;
      endcase
   endfunction

   // First n cycles of a tone as seen after the starting edge.
   task automatic push_tone(input logic [1:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         int j, d;
         logic s;
         if (code == 2'b11 && i >= DUR) begin
            j = i - DUR;
            d = 2 * BAD_DIV;
         end else begin
            j = i;
            d = div_of(code);
         end
         s = (((j / d) % 2) == 0);
         exp_q.push_back({1'b1, code, s});
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed {busy,tone,spk}=%b expected=%b", tag, cycle, obs, expv);
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s cyc=%0d scoreboard empty, observed=%b expected=entry", tag, cycle,
                     {busy, tone_id, speaker});
         end else begin
            check(tag, {busy, tone_id, speaker}, exp_q.pop_front());
         end
      end
   endtask

   initial begin
      #1;
      check("reset", {busy, tone_id, speaker}, 4'b0000);
      @(negedge clk);
      nRst = 1'b1;
      push_idle(2);
      run(2, "idle");

      // move tone; held direction must not retrigger
      direction = 4'b0001;
      push_tone(2'b01, DUR);
      push_idle(6);
      run(DUR + 6, "move");
      direction = 4'b0000;
      push_idle(1);
      run(1, "move_clr");

      // good tone from a one-cycle pulse
      goodColl = 1'b1;
      push_tone(2'b10, DUR);
      push_idle(2);
      run(1, "good");
      goodColl = 1'b0;
      run(DUR + 1, "good");

      // bad tone, two segments
      badColl = 1'b1;
      push_tone(2'b11, 2 * DUR);
      push_idle(2);
      run(1, "bad");
      badColl = 1'b0;
      run(2 * DUR + 1, "bad");

      // simultaneous good and bad picks bad
      goodColl = 1'b1;
      badColl  = 1'b1;
      push_tone(2'b11, 2 * DUR);
      push_idle(1);
      run(1, "prio");
      goodColl = 1'b0;
      badColl  = 1'b0;
      run(2 * DUR, "prio");

      // bad pre-empts good at cycle 10
      goodColl = 1'b1;
      push_tone(2'b10, 10);
      run(1, "pre_good");
      goodColl = 1'b0;
      run(9, "pre_good");
      badColl = 1'b1;
      push_tone(2'b11, 2 * DUR);
      push_idle(2);
      run(1, "pre_bad");
      badColl = 1'b0;
      run(2 * DUR + 1, "pre_bad");

      // good and move during bad are dropped
      badColl = 1'b1;
      push_tone(2'b11, 2 * DUR);
      push_idle(2);
      run(1, "drop");
      badColl = 1'b0;
      run(4, "drop");
      goodColl = 1'b1;
      run(1, "drop");
      goodColl = 1'b0;
      direction = 4'b1000;
      run(1, "drop");
      direction = 4'b0000;
      run(2 * DUR - 7 + 2, "drop");

      // mode OFF ignores events; prev_dir still tracks
      mode_i    = 1'b0;
      goodColl  = 1'b1;
      badColl   = 1'b1;
      direction = 4'b0100;
      push_idle(3);
      run(3, "off");
      goodColl = 1'b0;
      badColl  = 1'b0;
      mode_i   = 1'b1;
      push_idle(3);
      run(3, "off_dir");
      direction = 4'b0000;
      push_idle(1);
      run(1, "off_dir");

      // mode drop mid-tone
      goodColl = 1'b1;
      push_tone(2'b10, 5);
      run(1, "mode_drop");
      goodColl = 1'b0;
      run(4, "mode_drop");
      mode_i = 1'b0;
      push_idle(3);
      run(3, "mode_drop");
      mode_i = 1'b1;

      // async reset during SEG2
      badColl = 1'b1;
      push_tone(2'b11, DUR + 6);
      run(1, "areset");
      badColl = 1'b0;
      run(DUR + 5, "areset");
      #2;
      nRst = 1'b0;
      #1;
      check("areset_now", {busy, tone_id, speaker}, 4'b0000);
      @(negedge clk);
      nRst = 1'b1;
      push_idle(5);
      run(5, "post_reset");

      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL leftover observed=%0d entries expected=0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sound_tone_gen.md
# sound_tone_gen

Square-wave tone generator that sits directly downstream of the sound mode FSM. It consumes game events (good collision, bad collision, snake direction change) together with the FSM's ON/OFF mode, and drives a 1-bit speaker line. Each event type has its own pitch, and a bad collision plays a two-step descending tone. A higher-priority event pre-empts a tone that is already playing.

## Interface
Parameters:
- MOVE_DIV, default 2: half-period of the move tone, in clk cycles.
- GOOD_DIV, default 4: half-period of the good-collision tone, in clk cycles.
- BAD_DIV, default 6: half-period of the first bad-collision segment; the second segment uses 2*BAD_DIV.
- DUR, default 24: length of each tone segment, in clk cycles.
- Constraints: every *_DIV ≥ 1; DUR ≥ 1; 2*BAD_DIV and DUR each fit in 16 bits.

Ports:
- clk  in  1  system clock. One clock domain.
- nRst  in  1  reset. Asynchronous, active-low.
- mode_i  in  1  from the mode FSM: 1 = ON, 0 = OFF.
- goodColl  in  1  good-collision event, level-sampled each posedge.
- badColl  in  1  bad-collision event, level-sampled each posedge.
- direction  in  4  one-hot snake direction; 0000 means none.
- speaker  out  1  square-wave audio output.
- busy  out  1  high while a tone is playing.
- tone_id  out  2  tone in progress: 00 none, 01 move, 10 good, 11 bad.

## Operation
- States: IDLE, SEG1, SEG2. SEG2 is used only by the bad tone.
- Reset (asynchronous): state IDLE, speaker 0, busy 0, tone_id 00, all counters 0, prev_dir 0000.
- prev_dir is registered every cycle, including when mode is OFF.
- Move event: direction != prev_dir and direction != 0000.
- Priority: bad > good > move. Only the highest-priority event present in a cycle is considered.
- Start a tone when mode_i=1 and either:
  - state is IDLE and any event is present, or
  - the event's priority is strictly higher than the current tone_id.
- Events of equal or lower priority than the playing tone are dropped. They are not queued.
- On start, at the same edge:
  - state → SEG1, tone_id set to the event code;
  - speaker → 1;
  - half-period counter hp_cnt → 0, duration counter dur_cnt → 0;
  - half-period value set to MOVE_DIV, GOOD_DIV or BAD_DIV.
- In SEG1 or SEG2, each cycle:
  - hp_cnt increments. When hp_cnt == half-period−1, speaker toggles and hp_cnt → 0.
  - dur_cnt increments.
- When dur_cnt == DUR−1 in SEG1:
  - If tone_id is 11: state → SEG2, half-period → 2*BAD_DIV, speaker → 1, both counters → 0.
  - Otherwise: state → IDLE.
- When dur_cnt == DUR−1 in SEG2: state → IDLE.
- On entering IDLE: speaker 0, busy 0, tone_id 00.
- A start condition takes precedence over segment end on the same edge.
- If mode_i=0 at any posedge: state → IDLE with IDLE outputs, and all events are ignored.
- busy is 1 exactly when state != IDLE. All outputs are registered.

## Timing
- Event sampled at posedge k → busy=1, speaker=1 and tone_id valid after edge k. Latency is 1 cycle.
- speaker is high for DIV cycles, then low for DIV cycles, and repeats.
- Move or good tone: busy is high for exactly DUR cycles.
- Bad tone: busy is high for exactly 2*DUR cycles.
- Pre-emption restarts the timing from the pre-empting edge.
- A mode_i fall takes effect at the next posedge; outputs are 0 after that edge.
- Asserting nRst mid-tone clears the outputs immediately, without waiting for clk.
- A held direction produces one move event, not repeated events.

## Test plan
1. Reset, idle, move tone: hold nRst low mid-sim → speaker, busy, tone_id are 0 with no clk edge. Release, then raise direction 0000→0001 and hold it → tone_id=01; speaker pattern 1,1,0,0 repeated 6 times; busy for 24 cycles. No second tone follows.
2. Good tone: goodColl pulsed for 1 cycle → tone_id=10; speaker high 4 cycles / low 4 cycles, 3 full periods; busy 24 cycles; then tone_id=00.
3. Bad tone: badColl pulsed → first 24 cycles have half-period 6; the next 24 cycles have half-period 12 (12 high, 12 low); busy for 48 cycles; tone_id=11 throughout.
4. Priority and pre-emption:
   - goodColl and badColl in the same cycle → tone_id=11.
   - During a good tone, badColl at cycle 10 → restarts as bad tone; busy ends 48 cycles after the pre-emption.
   - During a bad tone, goodColl → ignored.
5. Mode gating: mode_i=0 with events → speaker stays 0, busy 0. mode_i dropped mid-tone → outputs 0 after the next posedge.
6. Async reset mid-operation: nRst asserted during SEG2 of a bad tone → outputs 0 immediately. After release and with no events → state stays IDLE.
